seq_divider: RTL and testbench

Sequential radix-2 restoring signed divider. It is the inverse companion to the team's sequential Booth multiplier and uses the same start/busy/done handshake style. It takes a WIDTH-bit two's-complement dividend and divisor and returns a quotient and remainder after a fixed latency. It sits beside the multiplier in the arithmetic unit and uses one shift-subtract step per clock.

---
 rtl/seq_divider_pkg.sv | 22 ++
 rtl/seq_divider_df_ac.sv | 26 ++
 rtl/seq_divider_div_step.sv | 30 +++
 rtl/seq_divider.sv | 197 +++++++++++++++++++
 tb/tb_seq_divider.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared definitions for the sequential restoring divider.
//   state_e - FSM state encoding (IDLE, RUN, FIX, DONE)
//   clog2   - bit width needed to count 0..value-1 (minimum 1)
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_divider_df_ac.sv
// df_ac: D flop with enable and asynchronous active-low clear. Member of the
// df flop family, used where state must drop to zero the moment reset asserts.
//   clk     - rising-edge clock
//   clr_n_i - asynchronous active-low clear (q_o -> 0)
//   en_i    - load enable
//   d_i     - data in  [WIDTH-1:0]
//   q_o     - data out [WIDTH-1:0]
module df_ac #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr_n_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk or negedge clr_n_i) begin
    if (!clr_n_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational radix-2 restoring division step.
//   rem_i  - partial remainder magnitude before the step [WIDTH-1:0]
//   bit_i  - next dividend bit shifted in below the remainder
//   dsr_i  - divisor magnitude [WIDTH:0]
//   rem_o  - partial remainder after the step
//   qbit_o - quotient bit produced by the step
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH:0]   dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The incoming remainder is always below the divisor magnitude
  // (<= 2^(WIDTH-1)), so the shifted value is below 2^WIDTH and a WIDTH+1-bit
  // subtract has a trustworthy sign bit.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - dsr_i;
    qbit_o  = ~diff[WIDTH];
    rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential radix-2 restoring signed divider, one step per clock.
//
// Handshake: start is accepted only in IDLE. busy is high while the
// operation runs (RUN and FIX). done is a one-cycle pulse; quotient,
// remainder, dbz and ovf are valid from that cycle and hold until the next
// accepted start (dbz/ovf clear at acceptance, results update in FIX).
//
// Ports:
//   clk       - rising-edge clock
//   reset_    - asynchronous active-low reset
//   start     - operation request
//   dividend  - signed dividend [WIDTH-1:0]
//   divisor   - signed divisor  [WIDTH-1:0]
//   quotient  - signed quotient, truncated toward zero
//   remainder - signed remainder, sign follows the dividend
//   busy      - operation in progress
//   done      - single-cycle completion pulse
//   dbz       - divide-by-zero flag
//   ovf       - overflow flag (most-negative / -1)
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             ovf
);

  import seq_divider_pkg::*;

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  prem_q;     // partial remainder magnitude
  logic [WIDTH-1:0]  dvd_q;      // dividend magnitude; quotient bits shift in at the bottom
  logic [WIDTH:0]    dsr_q;      // divisor magnitude
  logic [WIDTH-1:0]  dvd_raw_q;  // dividend as given, returned as remainder on divide-by-zero
  logic              qneg_q;
  logic              rneg_q;
  logic              dbz_pend_q;
  logic              ovf_pend_q;
  logic              busy_q;
  logic              done_q;

  // Operand magnitudes. The dividend magnitude is kept as an unsigned
  // WIDTH-bit field, which still holds 2^(WIDTH-1); the divisor magnitude is
  // WIDTH+1 bits because it feeds the WIDTH+1-bit trial subtract.
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH:0]   dsr_ext;
  logic [WIDTH:0]   dsr_mag;

  always_comb begin
    dvd_mag = dividend[WIDTH-1] ? (~dividend + ONE) : dividend;
    dsr_ext = {divisor[WIDTH-1], divisor};
    dsr_mag = divisor[WIDTH-1] ? (-dsr_ext) : dsr_ext;
  end

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (prem_q),
    .bit_i  (dvd_q[WIDTH-1]),
    .dsr_i  (dsr_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  logic accept;
  assign accept = (state_q == IDLE) && start;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prem_q     <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      dvd_raw_q  <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dbz_pend_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            dvd_q      <= dvd_mag;
            dsr_q      <= dsr_mag;
            dvd_raw_q  <= dividend;
            qneg_q     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_q     <= dividend[WIDTH-1];
            prem_q     <= '0;
            cnt_q      <= CNT_LAST;
            dbz_pend_q <= (divisor == '0);
            ovf_pend_q <= (dividend == MOST_NEG) && (divisor == '1);
            busy_q     <= 1'b1;
            state_q    <= (divisor == '0) ? FIX : RUN;
          end
        end
        RUN: begin
          prem_q <= step_rem;
          dvd_q  <= {dvd_q[WIDTH-2:0], step_qbit};
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        FIX: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // Result registers: loaded only in FIX so the previous results stay
  // visible while a new operation runs. Flags clear on acceptance.
  logic             res_en;
  logic             flag_en;
  logic [WIDTH-1:0] quot_d;
  logic [WIDTH-1:0] rem_d;
  logic [1:0]       flags_d;
  logic [1:0]       flags_q;

  always_comb begin
    res_en  = (state_q == FIX);
    flag_en = accept || res_en;
    flags_d = res_en ? {dbz_pend_q, ovf_pend_q} : 2'b00;
    quot_d  = qneg_q ? (~dvd_q + ONE) : dvd_q;
    rem_d   = rneg_q ? (~prem_q + ONE) : prem_q;
    if (dbz_pend_q) begin
      quot_d = '1;
      rem_d  = dvd_raw_q;
    end else if (ovf_pend_q) begin
      quot_d = MOST_NEG;
      rem_d  = '0;
    end
  end

  df_ac #(.WIDTH(WIDTH)) u_quot_q (
    .clk     (clk),
    .clr_n_i (reset_),
    .en_i    (res_en),
    .d_i     (quot_d),
    .q_o     (quotient)
  );

  df_ac #(.WIDTH(WIDTH)) u_rem_q (
    .clk     (clk),
    .clr_n_i (reset_),
    .en_i    (res_en),
    .d_i     (rem_d),
    .q_o     (remainder)
  );

  df_ac #(.WIDTH(2)) u_flags_q (
    .clk     (clk),
    .clr_n_i (reset_),
    .en_i    (flag_en),
    .d_i     (flags_d),
    .q_o     (flags_q)
  );

  assign dbz = flags_q[1];
  assign ovf = flags_q[0];

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and swept checks of seq_divider (WIDTH=8).
// Drivers push the expected result and its done cycle into exp_q when an
// operation is issued; the monitor pops and compares on every done pulse.
module tb_seq_divider;

  localparam int W  = 8;
  localparam int EW = 32 + W + W + 2;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset_;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         dbz;
  logic         ovf;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_    (reset_),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  // ---------------- scoreboard ----------------
  // entry = {done_cycle[31:0], quotient, remainder, dbz, ovf}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_op(input int done_cyc, input logic [W-1:0] q, input logic [W-1:0] r,
                           input logic z, input logic o);
    exp_q.push_back({32'(done_cyc), q, r, z, o});
  endtask

  always @(negedge clk) begin
    if (reset_ === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1, want no pending operation (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_cycle", 32'(cyc), mon_e[EW-1 -: 32]);
        check("quotient", 32'(quotient), 32'(mon_e[2*W+1 -: W]));
        check("remainder", 32'(remainder), 32'(mon_e[W+1 -: W]));
        check("dbz", 32'(dbz), 32'(mon_e[1]));
        check("ovf", 32'(ovf), 32'(mon_e[0]));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=%0b done=%0b after 200 cycles, want idle", busy, done);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                       input logic [W-1:0] r, input logic z, input logic o);
    wait_idle();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    expect_op(cyc + ((b == '0) ? 2 : W + 2), q, r, z, o);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_quotient"}, 32'(quotient), 32'd0);
    check({tag, "_remainder"}, 32'(remainder), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_dbz"}, 32'(dbz), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  // reference model for the sweep: C-style truncating division
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, output logic [W-1:0] q,
                       output logic [W-1:0] r, output logic z, output logic o);
    int ia, ib, iq, ir;
    ia = int'($signed(a));
    ib = int'($signed(b));
    if (ib == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
      o = 1'b0;
    end else begin
      iq = ia / ib;
      ir = ia % ib;
      if (ia == -(1 << (W - 1)) && ib == -1) begin
        iq = -(1 << (W - 1));
        ir = 0;
      end
      q = iq[W-1:0];
      r = ir[W-1:0];
      z = 1'b0;
      o = (ia == -(1 << (W - 1))) && (ib == -1);
    end
  endtask

  // directed vectors: dividend, divisor, quotient, remainder, dbz, ovf
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    logic         o;
  } vec_t;

  vec_t vecs[13] = '{
    '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0},  //  100 /  7
    '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0},  // -100 /  7
    '{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0},  //  100 / -7
    '{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0},  // -100 / -7
    '{8'h07, 8'h00, 8'hFF, 8'h07, 1'b1, 1'b0},  //    7 /  0
    '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1},  // -128 / -1
    '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0},  // -128 /  1
    '{8'h01, 8'h80, 8'h00, 8'h01, 1'b0, 1'b0},  //    1 / -128
    '{8'h80, 8'h00, 8'hFF, 8'h80, 1'b1, 1'b0},  // -128 /  0
    '{8'h05, 8'h0A, 8'h00, 8'h05, 1'b0, 1'b0},  //    5 / 10
    '{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0},  //  127 / -128
    '{8'h80, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0},  // -128 / -128
    '{8'hFF, 8'h02, 8'h00, 8'hFF, 1'b0, 1'b0}   //   -1 /  2
  };

  logic [W-1:0] sp[6] = '{8'h00, 8'h01, 8'hFF, 8'h80, 8'h7F, 8'h02};

  // ---------------- main sequence ----------------
  initial begin
    int c;
    logic [W-1:0] ra, rb, rq, rr;
    logic rz, ro;

    reset_   = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_ = 1'b1;
    @(negedge clk);

    // first operation with a per-cycle busy profile: high in cycles 1..9
    wait_idle();
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    c = cyc;
    expect_op(c + W + 2, 8'h0E, 8'h02, 1'b0, 1'b0);
    check("busy_c0", 32'(busy), 32'd0);
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      check($sformatf("busy_c%0d", k), 32'(busy), (k <= W + 1) ? 32'd1 : 32'd0);
    end

    // directed table
    foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].o);
    drain();

    // start held high across two operations; operands only captured at acceptance
    wait_idle();
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    c = cyc;
    expect_op(c + W + 2, 8'h0E, 8'h02, 1'b0, 1'b0);
    expect_op(c + 2 * W + 5, 8'h0A, 8'h00, 1'b0, 1'b0);
    for (int k = 1; k <= 2 * W + 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        dividend = 8'd1;
        divisor  = 8'd1;
      end
      if (k == W + 2) begin
        dividend = 8'd50;
        divisor  = 8'd5;
      end
    end
    start = 1'b0;
    drain();

    // start re-pulsed while busy and during done: ignored
    wait_idle();
    dividend = 8'd100;
    divisor  = 8'hF9;
    start    = 1'b1;
    c = cyc;
    expect_op(c + W + 2, 8'hF2, 8'h02, 1'b0, 1'b0);
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      start = (k == 3 || k == W + 1 || k == W + 2);
      if (k == 1) begin
        dividend = 8'd1;
        divisor  = 8'd1;
      end
    end
    start = 1'b0;
    drain();

    // reset during cycle 5 of RUN: outputs clear at once, no done
    wait_idle();
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    expect_op(cyc + W + 2, 8'h0E, 8'h02, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    reset_ = 1'b0;
    exp_q.delete();
    #1;
    check_outputs_zero("async_reset");
    repeat (3) @(negedge clk);
    check("reset_hold_done", 32'(done), 32'd0);
    reset_ = 1'b1;
    repeat (W + 4) @(negedge clk);
    check("post_reset_idle_busy", 32'(busy), 32'd0);
    issue(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 1'b0);
    drain();

    // sweep against the reference model, biased toward corner operands
    for (int n = 0; n < 2000; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : W'($urandom_range(0, 255));
      rb = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : W'($urandom_range(0, 255));
      model(ra, rb, rq, rr, rz, ro);
      issue(ra, rb, rq, rr, rz, ro);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by time %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
